// File: rtl/alu_op_pkg.sv
// Shared types and the fixed opcode decode table for the ALU opcode sequencer.
// Each table entry is {legal, cw[7:0], beats[2:0]}, indexed by opcode.
package alu_op_pkg;

  localparam int unsigned TableDepth = 16;
  localparam int unsigned EntryW     = 12;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  localparam logic [EntryW-1:0] DECODE_TABLE [TableDepth] = '{
    {1'b1, 8'h30, 3'd1},
    {1'b1, 8'h40, 3'd1},
    {1'b1, 8'h50, 3'd1},
    {1'b1, 8'h6A, 3'd1},
    {1'b1, 8'h7A, 3'd1},
    {1'b1, 8'h8A, 3'd1},
    {1'b1, 8'h9A, 3'd2},
    {1'b1, 8'hAA, 3'd2},
    {1'b1, 8'hBA, 3'd4},
    {1'b1, 8'hCA, 3'd4},
    {1'b1, 8'hDA, 3'd1},
    {1'b1, 8'hE0, 3'd1},
    {1'b1, 8'hFF, 3'd3},
    {1'b0, 8'h00, 3'd1},
    {1'b0, 8'h00, 3'd1},
    {1'b0, 8'h00, 3'd1}
  };

endpackage

// File: rtl/alu_op_rom.sv
// Combinational opcode decoder: opcode -> {legal, control word, beat count}.
// Codes outside the table, or marked illegal, yield ILLEGAL_CW with one beat.
module alu_op_rom #(
  parameter int unsigned      OPC_W      = 4,
  parameter int unsigned      CW_W       = 8,
  parameter logic [CW_W-1:0]  ILLEGAL_CW = '0
) (
  input  logic [OPC_W-1:0] opcode_i,
  output logic             legal_o,
  output logic [CW_W-1:0]  cw_o,
  output logic [2:0]       beats_o
);
  import alu_op_pkg::*;

  logic [31:0]       opc_ext;
  logic [3:0]        tbl_idx;
  logic              in_range;
  logic [EntryW-1:0] entry;

  always_comb begin
    opc_ext  = 32'(opcode_i);
    tbl_idx  = opc_ext[3:0];
    in_range = opc_ext < 32'(TableDepth);
    entry    = DECODE_TABLE[tbl_idx];
    legal_o  = in_range & entry[11];
    cw_o     = legal_o ? CW_W'(entry[10:3]) : ILLEGAL_CW;
    beats_o  = legal_o ? entry[2:0] : 3'd1;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU opcode sequencer: accepts one opcode per handshake and streams
// its control-word beats, tracking illegal opcodes with a saturating counter.
module alu_op_sequencer #(
  parameter int unsigned     OPC_W      = 4,
  parameter int unsigned     CW_W       = 8,
  parameter int unsigned     MAX_UOPS   = 4,
  parameter logic [CW_W-1:0] ILLEGAL_CW = '0,
  parameter int unsigned     CNT_W      = 8,
  localparam int unsigned    UW         = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [OPC_W-1:0] opcode_i,
  output logic             cw_valid_o,
  input  logic             cw_ready_i,
  output logic [CW_W-1:0]  cw_o,
  output logic [UW-1:0]    uop_idx_o,
  output logic             cw_last_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);
  import alu_op_pkg::*;

  state_e           state_q, state_d;
  logic [CW_W-1:0]  cw_q, cw_d;
  logic [UW-1:0]    idx_q, idx_d;
  logic [UW-1:0]    last_idx_q, last_idx_d;
  logic             cw_last_q, cw_last_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             rom_legal;
  logic [CW_W-1:0]  rom_cw;
  logic [2:0]       rom_beats;
  int unsigned      beats_clamped;
  logic [UW-1:0]    rom_last_idx;

  logic             op_ready;
  logic             accept;
  logic             beat_take;

  alu_op_rom #(
    .OPC_W      (OPC_W),
    .CW_W       (CW_W),
    .ILLEGAL_CW (ILLEGAL_CW)
  ) u_rom (
    .opcode_i (opcode_i),
    .legal_o  (rom_legal),
    .cw_o     (rom_cw),
    .beats_o  (rom_beats)
  );

  // Table beat counts above MAX_UOPS are clamped.
  always_comb begin
    beats_clamped = 32'(rom_beats);
    if (beats_clamped > MAX_UOPS) beats_clamped = MAX_UOPS;
    if (beats_clamped == 0) beats_clamped = 1;
    rom_last_idx = UW'(beats_clamped - 1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cw_q       <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      cw_last_q  <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cw_q       <= cw_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      cw_last_q  <= cw_last_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cw_d       = cw_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    cw_last_d  = cw_last_q;
    illegal_d  = illegal_q;
    cnt_d      = cnt_q;
    accept     = op_valid_i & op_ready;
    beat_take  = (state_q == StIssue) & cw_ready_i;

    if (flush_i) begin
      state_d   = StIdle;
      idx_d     = '0;
      cw_last_d = 1'b0;
    end else if (accept) begin
      state_d    = StIssue;
      cw_d       = rom_cw;
      idx_d      = '0;
      last_idx_d = rom_last_idx;
      cw_last_d  = (rom_last_idx == '0);
      illegal_d  = ~rom_legal;
      if (!rom_legal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end else if (beat_take && !cw_last_q) begin
      idx_d     = idx_q + UW'(1);
      cw_last_d = ((idx_q + UW'(1)) == last_idx_q);
    end else if (beat_take) begin
      state_d   = StIdle;
      idx_d     = '0;
      cw_last_d = 1'b0;
    end
  end

  always_comb begin
    op_ready      = rst_ni & ~flush_i &
                    ((state_q == StIdle) | ((state_q == StIssue) & cw_ready_i & cw_last_q));
    op_ready_o    = op_ready;
    cw_valid_o    = (state_q == StIssue);
    cw_o          = cw_q;
    uop_idx_o     = idx_q;
    cw_last_o     = cw_last_q;
    illegal_o     = illegal_q;
    illegal_cnt_o = cnt_q;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: a queue of expected beats plus an
// illegal-opcode tally predicts every output each cycle.
module tb_alu_op_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic       op_valid_i;
  logic       op_ready_o;
  logic [3:0] opcode_i;
  logic       cw_valid_o;
  logic       cw_ready_i;
  logic [7:0] cw_o;
  logic [1:0] uop_idx_o;
  logic       cw_last_o;
  logic       illegal_o;
  logic [7:0] illegal_cnt_o;

  alu_op_sequencer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .op_valid_i    (op_valid_i),
    .op_ready_o    (op_ready_o),
    .opcode_i      (opcode_i),
    .cw_valid_o    (cw_valid_o),
    .cw_ready_i    (cw_ready_i),
    .cw_o          (cw_o),
    .uop_idx_o     (uop_idx_o),
    .cw_last_o     (cw_last_o),
    .illegal_o     (illegal_o),
    .illegal_cnt_o (illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] cw;
    logic [1:0] idx;
    logic       last;
    logic       ill;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned exp_cnt;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] ref_cw    [16] = '{8'h30, 8'h40, 8'h50, 8'h6A, 8'h7A, 8'h8A, 8'h9A, 8'hAA,
                                 8'hBA, 8'hCA, 8'hDA, 8'hE0, 8'hFF, 8'h00, 8'h00, 8'h00};
  int unsigned ref_beats [16] = '{1, 1, 1, 1, 1, 1, 2, 2, 4, 4, 1, 1, 3, 1, 1, 1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the edge, compare at the falling edge,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input logic rst, input logic opv, input logic [3:0] opc,
                      input logic cwr, input logic fl);
    logic  exp_ready;
    beat_t b;
    @(posedge clk_i);
    #1;
    rst_ni     = rst;
    op_valid_i = opv;
    opcode_i   = opc;
    cw_ready_i = cwr;
    flush_i    = fl;
    @(negedge clk_i);
    exp_ready = rst && !fl && (exp_q.size() == 0 || (cwr && exp_q.size() == 1));
    check_eq("op_ready", 32'(op_ready_o), 32'(exp_ready));
    check_eq("cw_valid", 32'(cw_valid_o), 32'(exp_q.size() != 0));
    check_eq("illegal_cnt", 32'(illegal_cnt_o), exp_cnt);
    if (exp_q.size() != 0) begin
      b = exp_q[0];
      check_eq("cw", 32'(cw_o), 32'(b.cw));
      check_eq("uop_idx", 32'(uop_idx_o), 32'(b.idx));
      check_eq("cw_last", 32'(cw_last_o), 32'(b.last));
      check_eq("illegal", 32'(illegal_o), 32'(b.ill));
    end
    if (!rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && cwr) void'(exp_q.pop_front());
      if (opv && exp_ready) begin
        for (int i = 0; i < int'(ref_beats[opc]); i++) begin
          b.cw   = ref_cw[opc];
          b.idx  = 2'(i);
          b.last = (i == int'(ref_beats[opc]) - 1);
          b.ill  = (opc >= 4'hD);
          exp_q.push_back(b);
        end
        if (opc >= 4'hD && exp_cnt < 255) exp_cnt++;
      end
    end
  endtask

  initial begin
    rst_ni     = 1'b0;
    flush_i    = 1'b0;
    op_valid_i = 1'b0;
    opcode_i   = '0;
    cw_ready_i = 1'b0;
    exp_cnt    = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_op_ready", 32'(op_ready_o), 32'd0);
    check_eq("rst_cw_valid", 32'(cw_valid_o), 32'd0);
    check_eq("rst_cw", 32'(cw_o), 32'd0);
    check_eq("rst_uop_idx", 32'(uop_idx_o), 32'd0);
    check_eq("rst_cw_last", 32'(cw_last_o), 32'd0);
    check_eq("rst_illegal", 32'(illegal_o), 32'd0);
    check_eq("rst_illegal_cnt", 32'(illegal_cnt_o), 32'd0);

    // Single, multi-beat and back-to-back opcodes.
    step(1, 1, 4'h2, 1, 0);
    step(1, 0, 4'h0, 1, 0);
    step(1, 0, 4'h0, 1, 0);
    step(1, 1, 4'h8, 1, 0);
    repeat (5) step(1, 0, 4'h0, 1, 0);
    step(1, 1, 4'h0, 1, 0);
    step(1, 1, 4'h1, 1, 0);
    step(1, 1, 4'h3, 1, 0);
    step(1, 0, 4'h0, 1, 0);
    step(1, 0, 4'h0, 1, 0);
    // Stall on a 2-beat opcode.
    step(1, 1, 4'h6, 0, 0);
    repeat (3) step(1, 0, 4'h0, 0, 0);
    repeat (3) step(1, 0, 4'h0, 1, 0);
    // Flush in the middle of a 4-beat opcode, then restart.
    step(1, 1, 4'h9, 1, 0);
    step(1, 0, 4'h0, 1, 0);
    step(1, 1, 4'h4, 1, 1);
    step(1, 1, 4'hC, 1, 0);
    repeat (4) step(1, 0, 4'h0, 1, 0);
    // Illegal opcodes until the counter saturates.
    step(1, 1, 4'hF, 1, 0);
    for (int i = 0; i < 300; i++) step(1, 1, 4'(13 + (i % 3)), 1, 0);
    repeat (2) step(1, 0, 4'h0, 1, 0);
    check_eq("illegal_cnt_sat", 32'(illegal_cnt_o), 32'd255);

    // Random traffic with stalls, flushes and occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 400; i++) begin
      step(1'b1, $urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), 1'b1,
           $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
